// File: rtl/bitonic_pkg.sv
// Shared sizing and FSM state type for the bitonic sorter output stage.
package bitonic_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int NUM_ELEM   = 8;
  localparam int CNT_W      = $clog2(NUM_ELEM);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/bitonic_order_chk.sv
// Flags a vector whose adjacent elements are not in ascending (non-strict) order.
module bitonic_order_chk
  import bitonic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] nums [NUM_ELEM],
  output logic              unsorted
);

  always_comb begin
    unsorted = 1'b0;
    for (int k = 0; k < NUM_ELEM - 1; k++) begin
      if (nums[k] > nums[k+1]) unsorted = 1'b1;
    end
  end

endmodule

// File: rtl/bitonic_serializer.sv
// Captures an 8-element sorted vector and streams it out one element per beat, smallest first.
// Optional ascending-order check enabled with macro BITONIC_SER_CHECK_EN.
module bitonic_serializer
  import bitonic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] number_in1,
  input  logic [DATA_W-1:0] number_in2,
  input  logic [DATA_W-1:0] number_in3,
  input  logic [DATA_W-1:0] number_in4,
  input  logic [DATA_W-1:0] number_in5,
  input  logic [DATA_W-1:0] number_in6,
  input  logic [DATA_W-1:0] number_in7,
  input  logic [DATA_W-1:0] number_in8,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              order_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ELEM - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] buffer [NUM_ELEM];
  logic [DATA_W-1:0] nums   [NUM_ELEM];
  logic              last_beat;
  logic              capture;
  logic              beat;

  assign nums[0] = number_in1;
  assign nums[1] = number_in2;
  assign nums[2] = number_in3;
  assign nums[3] = number_in4;
  assign nums[4] = number_in5;
  assign nums[5] = number_in6;
  assign nums[6] = number_in7;
  assign nums[7] = number_in8;

  assign last_beat = (cnt == LAST_CNT);
  assign out_valid = (state == SEND);
  assign out_data  = buffer[cnt];
  assign out_last  = out_valid && last_beat;
  assign beat      = out_valid && out_ready;

  // Accepting during the final beat lets consecutive vectors stream with no bubble.
  assign in_ready = rst_n && ((state == IDLE) || (last_beat && out_ready));
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      for (int i = 0; i < NUM_ELEM; i++) buffer[i] <= '0;
    end else if (capture) begin
      state  <= SEND;
      cnt    <= '0;
      buffer <= nums;
    end else if (beat) begin
      cnt <= cnt + 1'b1;
      if (last_beat) state <= IDLE;
    end
  end

`ifdef BITONIC_SER_CHECK_EN
  logic unsorted;
  logic err_q;

  bitonic_order_chk #(.DATA_W(DATA_W)) u_order_chk (
    .nums     (nums),
    .unsorted (unsorted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (capture) err_q <= unsorted;
  end

  assign order_err = err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: doc/bitonic_serializer.md
BITONIC_SERIALIZER -- requirements
Module: bitonic_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the width of each sorted number.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports number_in1..number_in8, input, DATA_W each: ascending-sorted vector from the stage-3 merge, with number_in1 the smallest.
REQ-005 SHALL have port in_valid, input, 1 bit: the number_in1..8 vector is valid this cycle.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-007 SHALL have port out_data, output, DATA_W: the current serial element.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts out_data this cycle.
REQ-010 SHALL have port out_last, output, 1 bit: out_data is the 8th element of the vector.
REQ-011 SHALL have port order_err, output, 1 bit: the captured vector was not ascending (see Configuration).

Function
REQ-012 SHALL capture a vector when in_valid and in_ready are both 1, storing all 8 elements into an 8-entry buffer.
REQ-013 SHALL implement a two-state FSM: IDLE (no data held) and SEND (streaming the buffer).
REQ-014 SHALL move IDLE->SEND on capture; SEND->IDLE on acceptance of the last beat with no new capture; SEND->SEND on last-beat acceptance with a simultaneous capture.
REQ-015 SHALL drive in_ready=1 in IDLE, and in SEND only when cnt==7 and out_ready==1, giving zero-bubble back-to-back vectors.
REQ-016 SHALL keep a 3-bit beat counter cnt, set to 0 on capture, incremented on each out_valid&&out_ready, and wrapping 7->0 on the last beat.
REQ-017 SHALL drive out_valid=1 exactly when in SEND, with out_data=buffer[cnt] and out_last=(cnt==7).
REQ-018 SHALL emit number_in1 first and number_in8 last, one element per accepted beat.
REQ-019 SHALL first present out_valid=1 one cycle after capture (latency 1), with element 1 in that cycle.
REQ-020 SHALL hold out_data, out_last and cnt stable while out_valid=1 and out_ready=0.
REQ-021 SHALL ignore in_valid whenever in_ready=0, leaving the buffer unchanged.

Reset
REQ-022 SHALL, while rst_n=0, force: state IDLE, cnt 0, buffer all 0, out_valid 0, out_data 0, out_last 0, order_err 0, in_ready 0.
REQ-023 SHALL, on reset asserted mid-stream, discard the partial vector; after release, in_ready=1 in the first cycle and no beat of the old vector is emitted.

Configuration
REQ-024 SHALL, with macro BITONIC_SER_CHECK_EN defined, on capture set order_err to 1 if any number_in(k) > number_in(k+1) for k=1..7, else 0, holding the value until the next capture.
REQ-025 SHALL, without BITONIC_SER_CHECK_EN, tie order_err to 0 and synthesise no comparators.

Structure
REQ-026 SHALL take DATA_W default, NUM_ELEM=8 and the FSM state type {IDLE, SEND} from shared package bitonic_pkg.
REQ-027 SHALL place the 7 adjacent-pair comparators in sub-module bitonic_order_chk, instantiated only under BITONIC_SER_CHECK_EN.

Verification
REQ-028 SHALL be verified with in 1,2,3,4,5,6,7,8, in_valid pulse, out_ready=1 -> out_data 1..8 on 8 consecutive cycles starting 1 cycle after capture, out_last only with 8, in_ready=0 during beats 1-7.
REQ-029 SHALL be verified with out_ready toggling 1,0,0,1,... -> no element dropped or duplicated, and out_data held during stalls.
REQ-030 SHALL be verified with two vectors (10..17, then 20..27) where in_valid stays high -> 16 contiguous beats, second vector captured on the cycle of 17, no idle cycle.
REQ-031 SHALL be verified with rst_n pulsed low after beat 3 -> outputs 0 immediately; after release in_ready=1, and a new vector streams from its element 1.
REQ-032 SHALL be verified, with BITONIC_SER_CHECK_EN defined, on input 1,2,9,4,5,6,7,8 -> order_err=1 from the cycle after capture, cleared by the next sorted vector; without the macro, order_err stays 0.
